// File: rtl/pipe_fetch.sv
// Instruction fetch/issue stage: loadable 24-bit program store, issues one decoded
// instruction per unstalled cycle until a HALT opcode or the end of the store.
module pipe_fetch #(
  parameter int          PC_W      = 8,
  parameter logic [3:0]  HALT_FUNC = 4'hF
) (
  input  logic            clk1,
  input  logic            rst,
  input  logic            start,
  input  logic            stall,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [23:0]     prog_data,
  output logic [7:0]      rs1,
  output logic [7:0]      rs2,
  output logic [7:0]      rd,
  output logic [7:0]      func,
  output logic [7:0]      addr,
  output logic            valid,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     issue_cnt
);

  localparam int DEPTH = 2 ** PC_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [23:0]     mem_q [DEPTH];
  logic [23:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;

  logic [23:0] word;
  logic        halt_hit, at_end, issue;

  assign word     = mem_q[pc_q];
  assign halt_hit = (word[23:20] == HALT_FUNC);
  assign at_end   = (pc_q == {PC_W{1'b1}});
  assign issue    = (state_q == S_RUN) && !stall && !halt_hit;

  // Store is deliberately left out of reset so a restart reuses the loaded program.
  always_ff @(posedge clk1) begin
    if (prog_we && state_q != S_RUN) mem_q[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      pc_q     <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RUN;
      S_RUN:          if (!stall && (halt_hit || at_end)) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    instr_d  = instr_q;
    valid_d  = 1'b0;
    if (state_q != S_RUN && start) begin
      pc_d  = '0;
      cnt_d = '0;
    end
    if (issue) begin
      instr_d = word;
      valid_d = 1'b1;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      // The last store slot ends the run instead of wrapping back to 0.
      if (!at_end) pc_d = pc_q + 1'b1;
    end
    busy_d   = (state_d == S_RUN);
    halted_d = (state_d == S_DONE);
  end

  assign func      = {4'h0, instr_q[23:20]};
  assign rd        = {4'h0, instr_q[19:16]};
  assign rs1       = {4'h0, instr_q[15:12]};
  assign rs2       = {4'h0, instr_q[11:8]};
  assign addr      = instr_q[7:0];
  assign valid     = valid_q;
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_fetch.sv
// Scoreboard bench for pipe_fetch: expected issues are queued by the stimulus and
// popped by a monitor whenever valid is seen.
module tb_pipe_fetch;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic        rst = 1'b1;
  logic        start = 1'b0, stall = 1'b0, prog_we = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic [23:0] prog_data = '0;
  logic [7:0]  rs1, rs2, rd, func, addr, pc;
  logic        valid, busy, halted;
  logic [15:0] issue_cnt;

  logic        start3 = 1'b0, prog_we3 = 1'b0;
  logic [2:0]  prog_addr3 = '0;
  logic [23:0] prog_data3 = '0;
  logic [7:0]  rs1_3, rs2_3, rd_3, func_3, addr_3;
  logic [2:0]  pc3;
  logic        valid3, busy3, halted3;
  logic [15:0] issue_cnt3;

  pipe_fetch #(.PC_W(8)) u_dut (
    .clk1(clk1), .rst(rst), .start(start), .stall(stall), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .rs1(rs1), .rs2(rs2), .rd(rd),
    .func(func), .addr(addr), .valid(valid), .pc(pc), .busy(busy), .halted(halted),
    .issue_cnt(issue_cnt));

  pipe_fetch #(.PC_W(3)) u_dut3 (
    .clk1(clk1), .rst(rst), .start(start3), .stall(1'b0), .prog_we(prog_we3),
    .prog_addr(prog_addr3), .prog_data(prog_data3), .rs1(rs1_3), .rs2(rs2_3), .rd(rd_3),
    .func(func_3), .addr(addr_3), .valid(valid3), .pc(pc3), .busy(busy3), .halted(halted3),
    .issue_cnt(issue_cnt3));

  logic [39:0] q[$];
  logic [39:0] q3[$];
  int checks = 0, errors = 0;
  int n_iss = 0, n_iss3 = 0;
  logic [23:0] prog [7];
  logic [23:0] HALT_W;

  function automatic logic [23:0] mk(int f, int d, int r1, int r2, int a);
    return {f[3:0], d[3:0], r1[3:0], r2[3:0], a[7:0]};
  endfunction

  function automatic logic [39:0] exp_of(logic [23:0] w);
    return {4'h0, w[23:20], 4'h0, w[19:16], 4'h0, w[15:12], 4'h0, w[11:8], w[7:0]};
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk1) begin
    if (valid === 1'b1) begin
      n_iss++;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_issue: got %0h expected none", {func, rd, rs1, rs2, addr});
      end else chk("issue_fields", {func, rd, rs1, rs2, addr}, q.pop_front());
    end
    if (valid3 === 1'b1) begin
      n_iss3++;
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_issue3: got %0h expected none", {func_3, rd_3, rs1_3, rs2_3, addr_3});
      end else chk("issue_fields3", {func_3, rd_3, rs1_3, rs2_3, addr_3}, q3.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk1);
    @(negedge clk1);
  endtask

  task automatic load(input logic [7:0] a, input logic [23:0] w);
    prog_we = 1'b1; prog_addr = a; prog_data = w;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_prog();
    for (int i = 0; i < 6; i++) q.push_back(exp_of(prog[i]));
  endtask

  task automatic wait_halt(output int n);
    n = 0;
    while (halted !== 1'b1 && n < 50) begin tick(); n++; end
    if (halted !== 1'b1) chk("halt_timeout", 40'(halted), 40'd1);
  endtask

  task automatic wait_halt3(output int n);
    n = 0;
    while (halted3 !== 1'b1 && n < 50) begin tick(); n++; end
    if (halted3 !== 1'b1) chk("halt3_timeout", 40'(halted3), 40'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    logic [23:0] neww;
    prog[0] = mk(0, 10, 5, 3, 125);
    prog[1] = mk(1, 11, 3, 2, 126);
    prog[2] = mk(2, 12, 4, 1, 127);
    prog[3] = mk(3, 13, 2, 5, 128);
    prog[4] = mk(4, 14, 1, 4, 129);
    prog[5] = mk(5, 15, 0, 6, 130);
    HALT_W  = mk(15, 0, 0, 0, 0);
    prog[6] = HALT_W;

    @(negedge clk1); @(negedge clk1);
    rst = 1'b0;
    chk("reset_outputs", {func, rd, rs1, rs2, addr}, 40'd0);
    chk("reset_status", {29'd0, valid, busy, halted, pc}, 40'd0);
    chk("reset_cnt", 40'(issue_cnt), 40'd0);

    // Basic issue
    for (int i = 0; i < 7; i++) load(8'(i), prog[i]);
    base = n_iss; push_prog(); go();
    chk("t1_busy", 40'(busy), 40'd1);
    wait_halt(n);
    chk("t1_halt_cycle", 40'(n), 40'd7);
    chk("t1_pc", 40'(pc), 40'd6);
    chk("t1_cnt", 40'(issue_cnt), 40'd6);
    chk("t1_issues", 40'(n_iss - base), 40'd6);
    chk("t1_valid_done", 40'(valid), 40'd0);
    chk("t1_fields_hold", {func, rd, rs1, rs2, addr}, exp_of(prog[5]));

    // Stall during the third issue slot
    base = n_iss; push_prog(); go();
    tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_stall_valid", 40'(valid), 40'd0);
      chk("t2_stall_fields", {func, rd, rs1, rs2, addr}, exp_of(prog[1]));
      chk("t2_stall_pc", 40'(pc), 40'd2);
      chk("t2_stall_cnt", 40'(issue_cnt), 40'd2);
    end
    stall = 1'b0;
    tick();
    chk("t2_resume_valid", 40'(valid), 40'd1);
    wait_halt(n);
    chk("t2_halt_cycle", 40'(n), 40'd4);
    chk("t2_issues", 40'(n_iss - base), 40'd6);
    chk("t2_cnt", 40'(issue_cnt), 40'd6);

    // Immediate halt
    load(8'd0, HALT_W);
    base = n_iss; go();
    tick();
    chk("t3_halted", 40'(halted), 40'd1);
    chk("t3_busy", 40'(busy), 40'd0);
    chk("t3_cnt", 40'(issue_cnt), 40'd0);
    chk("t3_pc", 40'(pc), 40'd0);
    chk("t3_issues", 40'(n_iss - base), 40'd0);

    // Reset mid-run, then restart with store intact
    load(8'd0, prog[0]);
    push_prog(); go();
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_fields", {func, rd, rs1, rs2, addr}, 40'd0);
    chk("t5_rst_status", {29'd0, valid, busy, halted, pc}, 40'd0);
    chk("t5_rst_cnt", 40'(issue_cnt), 40'd0);
    q.delete();
    @(negedge clk1);
    rst = 1'b0;
    base = n_iss; push_prog(); go();
    wait_halt(n);
    chk("t5_issues", 40'(n_iss - base), 40'd6);
    chk("t5_cnt", 40'(issue_cnt), 40'd6);

    // Write protection during RUN
    base = n_iss; push_prog(); go();
    load(8'd3, mk(9, 9, 9, 9, 9));
    wait_halt(n);
    chk("t6_issues", 40'(n_iss - base), 40'd6);

    // Simultaneous write to address 0 and start from DONE
    neww = mk(6, 1, 2, 3, 200);
    base = n_iss;
    q.push_back(exp_of(neww));
    for (int i = 1; i < 6; i++) q.push_back(exp_of(prog[i]));
    prog_we = 1'b1; prog_addr = 8'd0; prog_data = neww; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    wait_halt(n);
    chk("t7_issues", 40'(n_iss - base), 40'd6);
    chk("t7_queue_empty", 40'(q.size()), 40'd0);

    // End of store on the 8-entry instance
    for (int i = 0; i < 8; i++) begin
      prog_we3 = 1'b1; prog_addr3 = 3'(i); prog_data3 = mk(i, i + 8, i, 7 - i, 200 + i);
      q3.push_back(exp_of(prog_data3));
      tick();
    end
    prog_we3 = 1'b0;
    base = n_iss3;
    start3 = 1'b1; tick(); start3 = 1'b0;
    wait_halt3(n);
    chk("t4_halt_cycle", 40'(n), 40'd8);
    chk("t4_pc", 40'(pc3), 40'd7);
    chk("t4_cnt", 40'(issue_cnt3), 40'd8);
    for (int i = 0; i < 3; i++) tick();
    chk("t4_pc_no_wrap", 40'(pc3), 40'd7);
    chk("t4_still_done", 40'(halted3), 40'd1);
    chk("t4_issues", 40'(n_iss3 - base), 40'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
